// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: 16-channel MFP68901-style interrupt controller (IER/IPR/ISR/IMR/VR,
// priority resolution, registered IRQ_N, IACK vector handshake).
module mfp_irq_ctrl #(
    parameter logic [7:0] SPURIOUS_VEC = 8'h18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ADDR,
    input  logic        DAT_WE,
    input  logic [7:0]  DAT_I,
    output logic [7:0]  DAT_O,
    input  logic [15:0] IRQ_SRC,
    input  logic        IACK,
    output logic        IRQ_N,
    output logic [7:0]  VEC_O,
    output logic        VEC_VALID
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t      state_q, state_d;
    logic [15:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d, imr_q, imr_d;
    logic [7:0]  vr_q, vr_d, vec_q, vec_d;
    logic        irq_n_q, vld_q, vld_d, iack_q;
    logic [15:0] elig, oh, msk_a, msk_b;
    logic [3:0]  cand;
    logic        found, blk, valid, take, hit;
    logic [8:0]  we;

    always_comb begin
        elig = ipr_q & imr_q;
        cand = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (elig[i]) begin
                cand = 4'(i);
                found = 1'b1;
            end
        end
        // in-service channels block themselves and everything below them
        blk = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i >= int'(cand) && isr_q[i]) blk = 1'b1;
        end
        valid = found && !(vr_q[3] && blk);
        take = (state_q == IDLE) && IACK && !iack_q;
        hit = take && valid;
        oh = 16'h1 << cand;
        for (int i = 0; i < 9; i++) we[i] = DAT_WE && (ADDR == 4'(i));
        msk_a = {DAT_I, 8'hff};
        msk_b = {8'hff, DAT_I};
        ier_d = ier_q;
        if (we[0]) ier_d[15:8] = DAT_I;
        if (we[1]) ier_d[7:0] = DAT_I;
        imr_d = imr_q;
        if (we[6]) imr_d[15:8] = DAT_I;
        if (we[7]) imr_d[7:0] = DAT_I;
        vr_d = we[8] ? DAT_I : vr_q;
        // clears first, then sets, so pulses and acks win over writes
        ipr_d = (ipr_q & ((we[0] || we[2]) ? msk_a : 16'hffff)
                       & ((we[1] || we[3]) ? msk_b : 16'hffff)
                       & (hit ? ~oh : 16'hffff)) | (IRQ_SRC & ier_d);
        isr_d = (isr_q & (we[4] ? msk_a : 16'hffff)
                       & (we[5] ? msk_b : 16'hffff)
                       & ((we[8] && !DAT_I[3]) ? 16'h0 : 16'hffff))
              | ((hit && vr_q[3]) ? oh : 16'h0);
        state_d = state_q;
        vld_d = vld_q;
        vec_d = vec_q;
        if (take) begin
            state_d = ACK;
            vld_d = 1'b1;
            vec_d = valid ? {vr_q[7:4], cand} : SPURIOUS_VEC;
        end else if (state_q == ACK && !IACK) begin
            state_d = IDLE;
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ier_q <= 16'h0;
            ipr_q <= 16'h0;
            isr_q <= 16'h0;
            imr_q <= 16'h0;
            vr_q <= 8'h0;
            vec_q <= 8'h0;
            vld_q <= 1'b0;
            irq_n_q <= 1'b1;
            iack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ier_q <= ier_d;
            ipr_q <= ipr_d;
            isr_q <= isr_d;
            imr_q <= imr_d;
            vr_q <= vr_d;
            vec_q <= vec_d;
            vld_q <= vld_d;
            irq_n_q <= ~valid;
            iack_q <= IACK;
        end
    end

    always_comb begin
        case (ADDR)
            4'd0: DAT_O = ier_q[15:8];
            4'd1: DAT_O = ier_q[7:0];
            4'd2: DAT_O = ipr_q[15:8];
            4'd3: DAT_O = ipr_q[7:0];
            4'd4: DAT_O = isr_q[15:8];
            4'd5: DAT_O = isr_q[7:0];
            4'd6: DAT_O = imr_q[15:8];
            4'd7: DAT_O = imr_q[7:0];
            4'd8: DAT_O = vr_q;
            default: DAT_O = 8'h00;
        endcase
    end

    assign IRQ_N = irq_n_q;
    assign VEC_O = vec_q;
    assign VEC_VALID = vld_q;
endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// tb_mfp_irq_ctrl: directed self-checking bench for mfp_irq_ctrl.
module tb_mfp_irq_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  ADDR = 4'd0;
    logic        DAT_WE = 1'b0;
    logic [7:0]  DAT_I = 8'h00;
    logic [7:0]  DAT_O;
    logic [15:0] IRQ_SRC = 16'h0;
    logic        IACK = 1'b0;
    logic        IRQ_N;
    logic [7:0]  VEC_O;
    logic        VEC_VALID;
    int          errors = 0;
    int          checks = 0;

    mfp_irq_ctrl dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DAT_WE(DAT_WE), .DAT_I(DAT_I),
        .DAT_O(DAT_O), .IRQ_SRC(IRQ_SRC), .IACK(IACK), .IRQ_N(IRQ_N),
        .VEC_O(VEC_O), .VEC_VALID(VEC_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkr(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ADDR = a;
        #1;
        chk(tag, DAT_O, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        ADDR = a;
        DAT_I = d;
        DAT_WE = 1'b1;
        step();
        DAT_WE = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] s);
        IRQ_SRC = s;
        step();
        IRQ_SRC = 16'h0;
    endtask

    initial begin
        step();
        step();
        RST = 1'b0;
        chk("rst_irq_n", {7'd0, IRQ_N}, 8'h01);
        chk("rst_vld", {7'd0, VEC_VALID}, 8'h00);
        chk("rst_vec", VEC_O, 8'h00);
        chkr("rst_ierb", 4'd1, 8'h00);
        chkr("rst_vr", 4'd8, 8'h00);
        chkr("unused_addr", 4'd12, 8'h00);

        wr(4'd1, 8'h20);
        wr(4'd7, 8'h20);
        wr(4'd8, 8'h48);
        pulse(16'h0020);
        chkr("en_iprb", 4'd3, 8'h20);
        chk("en_irq_n_early", {7'd0, IRQ_N}, 8'h01);
        step();
        chk("en_irq_n", {7'd0, IRQ_N}, 8'h00);

        IACK = 1'b1;
        step();
        chk("ack_vec", VEC_O, 8'h45);
        chk("ack_vld", {7'd0, VEC_VALID}, 8'h01);
        chkr("ack_iprb", 4'd3, 8'h00);
        chkr("ack_isrb", 4'd5, 8'h20);
        step();
        chk("ack_irq_n", {7'd0, IRQ_N}, 8'h01);
        IACK = 1'b0;
        step();
        chk("ack_drop_vld", {7'd0, VEC_VALID}, 8'h00);

        wr(4'd1, 8'h28);
        wr(4'd7, 8'h28);
        pulse(16'h0008);
        step();
        chkr("nest_iprb", 4'd3, 8'h08);
        chk("nest_blocked", {7'd0, IRQ_N}, 8'h01);
        wr(4'd0, 8'h20);
        wr(4'd6, 8'h20);
        pulse(16'h2000);
        step();
        chk("nest_hi_irq_n", {7'd0, IRQ_N}, 8'h00);
        IACK = 1'b1;
        step();
        chk("nest_vec", VEC_O, 8'h4D);
        chkr("nest_isra", 4'd4, 8'h20);
        IACK = 1'b0;
        step();
        wr(4'd4, 8'h00);
        step();
        chk("nest_still_blk", {7'd0, IRQ_N}, 8'h01);
        wr(4'd5, 8'hDF);
        chkr("nest_isrb_clr", 4'd5, 8'h00);
        step();
        chk("nest_ch3_elig", {7'd0, IRQ_N}, 8'h00);
        IACK = 1'b1;
        step();
        chk("nest_vec3", VEC_O, 8'h43);
        IACK = 1'b0;
        step();
        wr(4'd8, 8'h40);
        chkr("vr_s0_clr_isr", 4'd5, 8'h00);

        wr(4'd1, 8'h04);
        wr(4'd7, 8'h00);
        pulse(16'h0004);
        step();
        chkr("mask_iprb", 4'd3, 8'h04);
        chk("mask_irq_n", {7'd0, IRQ_N}, 8'h01);
        wr(4'd1, 8'h00);
        chkr("dis_iprb_clr", 4'd3, 8'h00);
        pulse(16'h0004);
        chkr("dis_discard", 4'd3, 8'h00);

        IACK = 1'b1;
        step();
        chk("spur_vec", VEC_O, 8'h18);
        chk("spur_vld", {7'd0, VEC_VALID}, 8'h01);
        IACK = 1'b0;
        step();

        wr(4'd1, 8'h01);
        wr(4'd7, 8'h01);
        pulse(16'h0001);
        step();
        chk("aeoi_irq_n", {7'd0, IRQ_N}, 8'h00);
        IACK = 1'b1;
        step();
        chk("aeoi_vec", VEC_O, 8'h40);
        chkr("aeoi_isrb", 4'd5, 8'h00);
        chkr("aeoi_iprb", 4'd3, 8'h00);
        IACK = 1'b0;
        step();
        wr(4'd8, 8'h48);
        pulse(16'h0001);
        IACK = 1'b1;
        step();
        chkr("s1_isrb", 4'd5, 8'h01);
        IACK = 1'b0;
        step();
        wr(4'd8, 8'h40);
        chkr("s0_isrb_clr", 4'd5, 8'h00);

        wr(4'd1, 8'h02);
        wr(4'd7, 8'h02);
        ADDR = 4'd3;
        DAT_I = 8'h00;
        DAT_WE = 1'b1;
        IRQ_SRC = 16'h0002;
        step();
        DAT_WE = 1'b0;
        IRQ_SRC = 16'h0;
        chkr("coll_set_wins", 4'd3, 8'h02);
        step();
        IACK = 1'b1;
        step();
        chk("coll_vec", VEC_O, 8'h41);
        chk("coll_vld", {7'd0, VEC_VALID}, 8'h01);
        RST = 1'b1;
        step();
        chk("rack_vld", {7'd0, VEC_VALID}, 8'h00);
        chk("rack_irq_n", {7'd0, IRQ_N}, 8'h01);
        chk("rack_vec", VEC_O, 8'h00);
        chkr("rack_ierb", 4'd1, 8'h00);
        chkr("rack_imrb", 4'd7, 8'h00);
        chkr("rack_vr", 4'd8, 8'h00);
        RST = 1'b0;
        IACK = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mfp_irq_ctrl.md
Name: mfp_irq_ctrl

Overview:
- 16-channel MFP68901 interrupt controller: registers IER/IPR/ISR/IMR/VR, priority resolution, IRQ_N generation, IACK vector handshake.
- Sits directly downstream of the mfp_timer instances and GPIP edge logic; consumes their one-cycle interrupt pulses (e.g. T_O_PULSE).
- Drives the CPU interrupt request and supplies the vector on acknowledge.

Parameters:
- SPURIOUS_VEC, 8'h18, vector returned when IACK finds no eligible channel.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- ADDR  in  4  register select: 0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR; 9-15 unused.
- DAT_WE  in  1  one-cycle write strobe for the ADDR register.
- DAT_I  in  8  write data.
- DAT_O  out  8  read data for ADDR, combinational; unused addresses read 8'h00.
- IRQ_SRC  in  16  one-cycle interrupt pulses; bit 15 highest priority, bit 0 lowest. "A" registers hold ch15:8, "B" registers hold ch7:0.
- IACK  in  1  CPU acknowledge, level; held high for the whole ack cycle.
- IRQ_N  out  1  interrupt request, active low, registered.
- VEC_O  out  8  vector number.
- VEC_VALID  out  1  high while VEC_O is valid for the current ack.

Behaviour:
- Reset (RST=1 at posedge): IER, IPR, ISR, IMR, VR = 0; IRQ_N = 1; VEC_O = 0; VEC_VALID = 0; IACK edge register = 0.
- Pending set: IRQ_SRC[i]=1 with IER[i]=1 sets IPR[i] at the next edge. Pulses on disabled channels are discarded. IMR does not gate pending.
- IER write: stores the data; every bit written 0 also clears the matching IPR bit in the same cycle.
- IPR write: bits written 0 clear; bits written 1 leave the bit unchanged.
- ISR write: same rule as IPR.
- IMR write and VR write: plain store.
- VR write with VR[3] (S) = 0 clears all ISR bits.
- Priority rule:
  - eligible[i] = IPR[i] & IMR[i].
  - cand = highest eligible i.
  - cand is valid only if no ISR bit at position >= cand is set.
- IRQ_N is registered: IRQ_N <= ~(valid cand exists).
- Latency: source pulse at edge n -> IPR set at n+1 -> IRQ_N low at n+2.
- Ack FSM, states IDLE, ACK:
  - IDLE -> ACK on an IACK rising edge (IACK=1, previous sample 0).
  - On that edge, using the cand evaluated in the same cycle:
    - Valid cand: VEC_O <= {VR[7:4], cand[3:0]}; IPR[cand] cleared; ISR[cand] set if VR[3]=1.
    - No valid cand: VEC_O <= SPURIOUS_VEC; no register changes.
  - VEC_VALID <= 1 from the next edge.
  - ACK -> IDLE when IACK=0; VEC_VALID <= 0 at that edge.
  - A new ack requires IACK to fall and rise again.
- Automatic EOI (VR[3]=0): ISR bits never set; ISR does not block any priority.
- Simultaneous events in one cycle:
  - Source pulse and IPR clear (by IPR write, IER write-0 or ack) on the same bit: set wins.
  - Source pulse on a channel whose IER bit is being written 0: discarded, IPR cleared.
  - ISR write-0 and ack setting the same ISR bit: set wins.
  - Register write and ack: the write applies to all bits except those changed by the ack, where the ack wins.
- Reset during ACK: FSM returns to IDLE, VEC_VALID = 0 immediately at that edge.
- DAT_O reflects register state after prior edges; there is no read side effect.

Test Plan:
- Enable: IERB=8'h20, IMRB=8'h20, VR=8'h48; pulse IRQ_SRC[5] -> IPRB=8'h20 one cycle later; IRQ_N=0 two cycles after the pulse.
- Ack: in the enable scenario, raise IACK -> next cycle VEC_O=8'h45, VEC_VALID=1, IPRB=0, ISRB=8'h20; IRQ_N=1; drop IACK -> VEC_VALID=0.
- Priority/nesting: ch5 in service; pulse ch3 -> IRQ_N stays 1; pulse ch13 (IERA=IMRA=8'h20) -> IRQ_N=0; ack -> VEC_O=8'h4D. Write ISRB=8'hDF -> ch3 becomes eligible again.
- Mask/disable: IMRB=0 with pending ch2 -> IPRB bit set, IRQ_N=1. Write IERB=0 -> IPRB=0. Pulse ch2 with IER=0 -> IPRB stays 0.
- Spurious/auto-EOI: VR=8'h40, no pending, raise IACK -> VEC_O=8'h18. With ch0 pending, ack -> VEC_O=8'h40 and ISRB stays 0. Writing VR S=0 while ISR=8'h01 clears ISR.
- Collision: IRQ_SRC[1] pulse in the same cycle as an IPRB write of 8'h00 -> IPRB bit1=1 afterwards. Assert RST during ACK -> all registers 0, IRQ_N=1, VEC_VALID=0.
